// File: rtl/id_ex_stage_pkg.sv
// Shared constants and ALU operation codes for the ID/EX pipeline stage.
package id_ex_stage_pkg;

   localparam int unsigned DataWDefault = 32;
   localparam int unsigned RaWDefault   = 5;
   localparam int unsigned ZeroReg      = 0;

   typedef enum logic [2:0] {
      AluAnd = 3'b000,
      AluOr  = 3'b001,
      AluAdd = 3'b010,
      AluSll = 3'b011,
      AluSub = 3'b110,
      AluSlt = 3'b111
   } alu_sig_e;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Per-operand forwarding mux: EX/MEM result beats MEM/WB result beats held register data.
module id_ex_stage_fwd_unit
   import id_ex_stage_pkg::*;
#(
   parameter int unsigned DATA_W = DataWDefault,
   parameter int unsigned RA_W   = RaWDefault
) (
   input  logic [RA_W-1:0]   i_src,
   input  logic [DATA_W-1:0] i_held,
   input  logic              i_mem_reg_write,
   input  logic [RA_W-1:0]   i_mem_rd,
   input  logic [DATA_W-1:0] i_mem_result,
   input  logic              i_wb_reg_write,
   input  logic [RA_W-1:0]   i_wb_rd,
   input  logic [DATA_W-1:0] i_wb_result,
   output logic [DATA_W-1:0] o_data
);

   logic w_mem_hit;
   logic w_wb_hit;

   // $zero is hard-wired, so a write to it must never be forwarded.
   assign w_mem_hit = i_mem_reg_write && (i_mem_rd != RA_W'(ZeroReg)) && (i_mem_rd == i_src);
   assign w_wb_hit  = i_wb_reg_write && (i_wb_rd != RA_W'(ZeroReg)) && (i_wb_rd == i_src);

   assign o_data = w_mem_hit ? i_mem_result :
                   w_wb_hit  ? i_wb_result  : i_held;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB capture bypass, load-use bubble insertion and operand forwarding.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int unsigned DATA_W = DataWDefault,
   parameter int unsigned RA_W   = RaWDefault
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [RA_W-1:0]   id_rs,
   input  logic [RA_W-1:0]   id_rt,
   input  logic [RA_W-1:0]   id_rd,
   input  logic [4:0]        id_shamt,
   input  logic [2:0]        id_alu_sig,
   input  logic              id_alu_src,
   input  logic              id_reg_dst,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_mem_to_reg,
   input  logic              mem_reg_write,
   input  logic [RA_W-1:0]   mem_rd,
   input  logic [DATA_W-1:0] mem_result,
   input  logic              wb_reg_write,
   input  logic [RA_W-1:0]   wb_rd,
   input  logic [DATA_W-1:0] wb_result,
   output logic [DATA_W-1:0] alu_dataA,
   output logic [DATA_W-1:0] alu_dataB,
   output logic [2:0]        alu_signal,
   output logic [4:0]        alu_shamt,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [RA_W-1:0]   ex_dest,
   output logic              ex_valid,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_mem_to_reg,
   output logic              load_use_hazard
);

   logic              r_valid;
   logic [DATA_W-1:0] r_rs_data, r_rt_data, r_imm;
   logic [RA_W-1:0]   r_rs, r_rt, r_rd;
   logic [4:0]        r_shamt;
   logic [2:0]        r_alu_sig;
   logic              r_alu_src, r_reg_dst, r_reg_write, r_mem_read, r_mem_write, r_mem_to_reg;

   logic              w_wb_live;
   logic [RA_W-1:0]   w_dest;
   logic              w_bubble;
   logic [DATA_W-1:0] w_fwd_rs, w_fwd_rt;

   assign w_wb_live = wb_reg_write && (wb_rd != RA_W'(ZeroReg));
   assign w_dest    = r_reg_dst ? r_rd : r_rt;

   assign load_use_hazard = r_valid && r_mem_read && (w_dest != RA_W'(ZeroReg)) &&
                            ((w_dest == id_rs) || (w_dest == id_rt)) && id_valid;

   // Flush, reset and a load-use bubble all leave an all-zero stage behind.
   assign w_bubble = rst || flush || (!stall && load_use_hazard);

   always_ff @(posedge clk) begin
      if (w_bubble) begin
         r_valid      <= 1'b0;
         r_rs_data    <= '0;
         r_rt_data    <= '0;
         r_imm        <= '0;
         r_rs         <= '0;
         r_rt         <= '0;
         r_rd         <= '0;
         r_shamt      <= '0;
         r_alu_sig    <= '0;
         r_alu_src    <= 1'b0;
         r_reg_dst    <= 1'b0;
         r_reg_write  <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_to_reg <= 1'b0;
      end else if (stall) begin
         // A held instruction must not miss a writeback that retires while it waits.
         if (w_wb_live && (wb_rd == r_rs)) r_rs_data <= wb_result;
         if (w_wb_live && (wb_rd == r_rt)) r_rt_data <= wb_result;
      end else begin
         r_valid      <= id_valid;
         r_rs_data    <= (w_wb_live && (wb_rd == id_rs)) ? wb_result : id_rs_data;
         r_rt_data    <= (w_wb_live && (wb_rd == id_rt)) ? wb_result : id_rt_data;
         r_imm        <= id_imm;
         r_rs         <= id_rs;
         r_rt         <= id_rt;
         r_rd         <= id_rd;
         r_shamt      <= id_shamt;
         r_alu_sig    <= id_alu_sig;
         r_alu_src    <= id_alu_src;
         r_reg_dst    <= id_reg_dst;
         r_reg_write  <= id_reg_write;
         r_mem_read   <= id_mem_read;
         r_mem_write  <= id_mem_write;
         r_mem_to_reg <= id_mem_to_reg;
      end
   end

   id_ex_stage_fwd_unit #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rs (
      .i_src          (r_rs),
      .i_held         (r_rs_data),
      .i_mem_reg_write(mem_reg_write),
      .i_mem_rd       (mem_rd),
      .i_mem_result   (mem_result),
      .i_wb_reg_write (wb_reg_write),
      .i_wb_rd        (wb_rd),
      .i_wb_result    (wb_result),
      .o_data         (w_fwd_rs)
   );

   id_ex_stage_fwd_unit #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rt (
      .i_src          (r_rt),
      .i_held         (r_rt_data),
      .i_mem_reg_write(mem_reg_write),
      .i_mem_rd       (mem_rd),
      .i_mem_result   (mem_result),
      .i_wb_reg_write (wb_reg_write),
      .i_wb_rd        (wb_rd),
      .i_wb_result    (wb_result),
      .o_data         (w_fwd_rt)
   );

   assign alu_dataA     = w_fwd_rs;
   assign alu_dataB     = r_alu_src ? r_imm : w_fwd_rt;
   assign ex_store_data = w_fwd_rt;
   assign alu_signal    = r_alu_sig;
   assign alu_shamt     = r_shamt;
   assign ex_dest       = w_dest;
   assign ex_valid      = r_valid;
   assign ex_reg_write  = r_reg_write;
   assign ex_mem_read   = r_mem_read;
   assign ex_mem_write  = r_mem_write;
   assign ex_mem_to_reg = r_mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed plus random bench for id_ex_stage, checked against a behavioural model of the stage.
module tb_id_ex_stage;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst, stall, flush, id_valid;
   logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
   logic [AW-1:0] id_rs, id_rt, id_rd;
   logic [4:0]    id_shamt;
   logic [2:0]    id_alu_sig;
   logic          id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
   logic          mem_reg_write, wb_reg_write;
   logic [AW-1:0] mem_rd, wb_rd;
   logic [DW-1:0] mem_result, wb_result;
   logic [DW-1:0] alu_dataA, alu_dataB, ex_store_data;
   logic [2:0]    alu_signal;
   logic [4:0]    alu_shamt;
   logic [AW-1:0] ex_dest;
   logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
   logic          load_use_hazard;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_W(DW), .RA_W(AW)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
      .id_alu_sig(id_alu_sig), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_mem_to_reg(id_mem_to_reg), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
      .mem_result(mem_result), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
      .wb_result(wb_result), .alu_dataA(alu_dataA), .alu_dataB(alu_dataB),
      .alu_signal(alu_signal), .alu_shamt(alu_shamt), .ex_store_data(ex_store_data),
      .ex_dest(ex_dest), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
      .load_use_hazard(load_use_hazard)
   );

   // Model of what the EX stage currently holds.
   typedef struct packed {
      logic          valid;
      logic [DW-1:0] rs_data, rt_data, imm;
      logic [AW-1:0] rs, rt, rd;
      logic [4:0]    shamt;
      logic [2:0]    sig;
      logic          alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
   } ex_t;

   ex_t m;

   function automatic logic hit(logic we, logic [AW-1:0] rd, logic [AW-1:0] r);
      return we && (rd != 0) && (rd == r);
   endfunction

   function automatic logic [DW-1:0] fwd(logic [AW-1:0] r, logic [DW-1:0] held);
      if (hit(mem_reg_write, mem_rd, r)) return mem_result;
      if (hit(wb_reg_write, wb_rd, r)) return wb_result;
      return held;
   endfunction

   function automatic logic [AW-1:0] dest();
      return m.reg_dst ? m.rd : m.rt;
   endfunction

   function automatic logic hazard();
      return m.valid && m.mem_read && (dest() != 0) &&
             ((dest() == id_rs) || (dest() == id_rt)) && id_valid;
   endfunction

   function automatic ex_t model_next();
      ex_t n = m;
      if (rst || flush) n = '0;
      else if (stall) begin
         if (hit(wb_reg_write, wb_rd, m.rs)) n.rs_data = wb_result;
         if (hit(wb_reg_write, wb_rd, m.rt)) n.rt_data = wb_result;
      end else if (hazard()) n = '0;
      else begin
         n.valid = id_valid;
         n.rs_data = hit(wb_reg_write, wb_rd, id_rs) ? wb_result : id_rs_data;
         n.rt_data = hit(wb_reg_write, wb_rd, id_rt) ? wb_result : id_rt_data;
         n.imm = id_imm; n.rs = id_rs; n.rt = id_rt; n.rd = id_rd;
         n.shamt = id_shamt; n.sig = id_alu_sig; n.alu_src = id_alu_src;
         n.reg_dst = id_reg_dst; n.reg_write = id_reg_write; n.mem_read = id_mem_read;
         n.mem_write = id_mem_write; n.mem_to_reg = id_mem_to_reg;
      end
      return n;
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ph);
      chk({ph, ":alu_dataA"}, alu_dataA, fwd(m.rs, m.rs_data));
      chk({ph, ":alu_dataB"}, alu_dataB, m.alu_src ? m.imm : fwd(m.rt, m.rt_data));
      chk({ph, ":store_data"}, ex_store_data, fwd(m.rt, m.rt_data));
      chk({ph, ":alu_signal"}, DW'(alu_signal), DW'(m.sig));
      chk({ph, ":alu_shamt"}, DW'(alu_shamt), DW'(m.shamt));
      chk({ph, ":ex_dest"}, DW'(ex_dest), DW'(dest()));
      chk({ph, ":ex_valid"}, DW'(ex_valid), DW'(m.valid));
      chk({ph, ":reg_write"}, DW'(ex_reg_write), DW'(m.reg_write));
      chk({ph, ":mem_read"}, DW'(ex_mem_read), DW'(m.mem_read));
      chk({ph, ":mem_write"}, DW'(ex_mem_write), DW'(m.mem_write));
      chk({ph, ":mem_to_reg"}, DW'(ex_mem_to_reg), DW'(m.mem_to_reg));
      chk({ph, ":hazard"}, DW'(load_use_hazard), DW'(hazard()));
   endtask

   // Settle inputs, optionally check, then clock once and advance the model.
   task automatic tick(input bit do_check);
      ex_t nxt;
      #1;
      if (do_check) check_all("pre");
      nxt = model_next();
      @(posedge clk);
      m = nxt;
      #1;
   endtask

   task automatic idle();
      rst = 0; stall = 0; flush = 0; id_valid = 0;
      id_rs_data = '0; id_rt_data = '0; id_imm = '0;
      id_rs = '0; id_rt = '0; id_rd = '0; id_shamt = '0; id_alu_sig = '0;
      id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0;
      id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
      mem_reg_write = 0; mem_rd = '0; mem_result = '0;
      wb_reg_write = 0; wb_rd = '0; wb_result = '0;
   endtask

   task automatic rand_inputs();
      rst = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 5) == 0);
      id_valid = 1'($urandom);
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_rs = AW'($urandom_range(0, 7)); id_rt = AW'($urandom_range(0, 7));
      id_rd = AW'($urandom_range(0, 7));
      id_shamt = 5'($urandom); id_alu_sig = 3'($urandom);
      id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom); id_reg_write = 1'($urandom);
      id_mem_read = ($urandom_range(0, 2) == 0); id_mem_write = 1'($urandom);
      id_mem_to_reg = 1'($urandom);
      mem_reg_write = 1'($urandom); mem_rd = AW'($urandom_range(0, 7)); mem_result = $urandom;
      wb_reg_write = 1'($urandom); wb_rd = AW'($urandom_range(0, 7)); wb_result = $urandom;
   endtask

   initial begin
      m = '0;
      // Reset from unknown state, then hold reset with live forwarding inputs.
      idle();
      rst = 1;
      tick(0);
      mem_reg_write = 1; mem_rd = 5'd3; mem_result = 32'hDEAD;
      wb_reg_write = 1; wb_rd = 5'd4; wb_result = 32'hBEEF;
      tick(1);
      check_all("reset");
      chk("rst_alu_dataA", alu_dataA, 32'h0);
      chk("rst_ex_valid", DW'(ex_valid), 32'h0);
      chk("rst_hazard", DW'(load_use_hazard), 32'h0);

      // Plain capture.
      idle();
      id_valid = 1; id_rs_data = 32'd5; id_rt_data = 32'd7; id_alu_sig = 3'b010;
      id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; id_reg_dst = 1; id_reg_write = 1;
      tick(1);
      idle();
      #1;
      chk("cap_dataA", alu_dataA, 32'd5);
      chk("cap_dataB", alu_dataB, 32'd7);
      chk("cap_signal", DW'(alu_signal), 32'd2);
      chk("cap_valid", DW'(ex_valid), 32'd1);
      chk("cap_dest", DW'(ex_dest), 32'd3);

      // MEM beats WB on the same source register.
      id_valid = 1; id_rs = 5'd3; id_rs_data = 32'h11; id_rt = 5'd6;
      tick(1);
      idle();
      mem_reg_write = 1; mem_rd = 5'd3; mem_result = 32'hAA;
      wb_reg_write = 1; wb_rd = 5'd3; wb_result = 32'hBB;
      #1;
      chk("dfwd_mem", alu_dataA, 32'hAA);
      check_all("dfwd_mem");
      mem_reg_write = 0;
      #1;
      chk("dfwd_wb", alu_dataA, 32'hBB);
      check_all("dfwd_wb");

      // Load-use: lw $8 in EX, consumer of $8 in ID.
      idle();
      id_valid = 1; id_mem_read = 1; id_mem_to_reg = 1; id_reg_write = 1;
      id_alu_src = 1; id_rt = 5'd8; id_rs = 5'd2;
      tick(1);
      idle();
      id_valid = 1; id_rs = 5'd8; id_rt = 5'd9; id_reg_write = 1;
      #1;
      chk("lu_hazard", DW'(load_use_hazard), 32'd1);
      tick(1);
      chk("lu_bubble_valid", DW'(ex_valid), 32'd0);
      chk("lu_bubble_mem_read", DW'(ex_mem_read), 32'd0);
      chk("lu_bubble_reg_write", DW'(ex_reg_write), 32'd0);
      chk("lu_hazard_clear", DW'(load_use_hazard), 32'd0);

      // Stall while WB retires into the held rt.
      idle();
      id_valid = 1; id_rt = 5'd4; id_rt_data = 32'h55; id_rs = 5'd1;
      tick(1);
      idle();
      stall = 1; wb_reg_write = 1; wb_rd = 5'd4; wb_result = 32'h1234;
      tick(1);
      wb_reg_write = 0; wb_result = '0;
      tick(1);
      stall = 0;
      #1;
      chk("stall_wb_dataB", alu_dataB, 32'h1234);
      check_all("stall_wb");

      // Flush wins over stall; reset wins over everything.
      idle();
      id_valid = 1; id_reg_write = 1; id_rs = 5'd2; id_rs_data = 32'h99;
      tick(1);
      flush = 1; stall = 1;
      tick(1);
      chk("flush_stall_valid", DW'(ex_valid), 32'd0);
      idle();
      id_valid = 1; id_reg_write = 1; id_mem_write = 1; id_rs = 5'd2; id_rs_data = 32'h99;
      id_alu_sig = 3'b111; id_shamt = 5'd9;
      tick(1);
      rst = 1; flush = 1;
      tick(1);
      idle();
      #1;
      chk("rst_flush_dataA", alu_dataA, 32'h0);
      chk("rst_flush_signal", DW'(alu_signal), 32'h0);
      chk("rst_flush_shamt", DW'(alu_shamt), 32'h0);
      chk("rst_flush_valid", DW'(ex_valid), 32'h0);
      chk("rst_flush_mem_write", DW'(ex_mem_write), 32'h0);

      // A write to $zero is never forwarded.
      id_valid = 1; id_rs = 5'd0; id_rs_data = 32'h77;
      tick(1);
      idle();
      mem_reg_write = 1; mem_rd = 5'd0; mem_result = 32'hFFFF;
      #1;
      chk("zero_no_fwd", alu_dataA, 32'h77);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         rand_inputs();
         tick(1);
      end
      idle();
      tick(1);
      check_all("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
